// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data access (MEM).
// Latency: grant on the edge after a request, completion on the mem_ready edge, one RESP cycle; minimum 3 cycles per access.
// Backpressure: mem_ready stretches BUSY indefinitely; stall_if/stall_mem hold each stage until its valid pulse.
//
// Ports:
//   clk, rst                                 clock, async active-high reset
//   if_req/if_addr -> if_rdata/if_valid      fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid   data requester
//   stall_if, stall_mem                      combinational pipeline stalls
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ready/mem_rdata   memory side
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       grant_is_data;
    logic       any_req;
    logic       pick_data;

    assign any_req = if_req | d_req;
    // Data has priority unless fetch has already lost LIMIT times in a row.
    assign pick_data = d_req & ~(if_req & (starve_cnt == LIMIT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_valid      <= 1'b0;
            d_valid       <= 1'b0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            grant_is_data <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_req       <= 1'b1;
                        grant_is_data <= pick_data;
                        if (pick_data) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            // Only a data win over a waiting fetch counts toward starvation.
                            if (if_req) begin
                                starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
                            end else begin
                                starve_cnt <= '0;
                            end
                        end else begin
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (grant_is_data) begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                end
                default: begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational outputs
    always_comb begin
        stall_if  = if_req & ~if_valid;
        stall_mem = d_req & ~d_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int wait_cfg = 0;
    int wcnt     = 0;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;
    resp_t exp_q[$];

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents seen by the bench: one fixed instruction word, a simple pattern elsewhere.
    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0062_8293;
        return {a[15:0], 16'h5A00} ^ 32'h1357_0000;
    endfunction

    assign mem_rdata = rdata_for(mem_addr);

    // Memory model: mem_ready rises after wait_cfg low cycles of an outstanding mem_req.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt < wait_cfg) begin
                mem_ready = 1'b0;
                wcnt      = wcnt + 1;
            end else begin
                mem_ready = 1'b1;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic resp_t mk(input logic is_data, input logic [31:0] rd);
        resp_t r;
        r.is_data = is_data;
        r.rdata   = rd;
        return r;
    endfunction

    // Monitor: every completion pulse is matched against the next expected response.
    always @(negedge clk) begin
        if (!rst && (if_valid || d_valid)) begin
            resp_t e;
            chk("valid_exclusive", {63'd0, if_valid & d_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {63'd0, d_valid}, 64'd2);
            end else begin
                e = exp_q.pop_front();
                chk("resp_source", {63'd0, d_valid}, {63'd0, e.is_data});
                chk("resp_rdata", {32'd0, d_valid ? d_rdata : if_rdata}, {32'd0, e.rdata});
            end
        end
    end

    initial begin
        int  n;
        int  nd;
        int  nf;
        int  ok_cnt;
        bit  done;

        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", {mem_req, mem_we, if_valid, d_valid, 60'd0} | {32'd0, mem_addr | mem_wdata | if_rdata | d_rdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fetch only, zero-wait memory
        wait_cfg = 0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0010;
        exp_q.push_back(mk(1'b0, 32'h0062_8293));
        n = 0; ok_cnt = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_req) ok_cnt += (mem_addr == 32'h10 && !mem_we) ? 1 : 100;
            if (stall_if) n++;
            if (if_valid) begin
                chk("fetch_stall_at_valid", {63'd0, stall_if}, 64'd0);
                if_req = 1'b0;
                done   = 1;
            end
        end
        chk("fetch_done", {63'd0, done}, 64'd1);
        chk("fetch_stall_cycles", 64'(n), 64'd1);
        chk("fetch_mem_cycles", 64'(ok_cnt), 64'd1);
        repeat (2) @(negedge clk);

        // Simultaneous requests: data first, fetch next
        if_req  = 1'b1;
        if_addr = 32'h0000_0014;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0100;
        exp_q.push_back(mk(1'b1, rdata_for(32'h100)));
        exp_q.push_back(mk(1'b0, rdata_for(32'h14)));
        n = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_if) n++;
            if (d_valid) d_req = 1'b0;
            if (if_valid) begin
                if_req = 1'b0;
                done   = 1;
            end
        end
        chk("simul_done", {63'd0, done}, 64'd1);
        chk("simul_stall_if_cycles", 64'(n), 64'd4);
        repeat (2) @(negedge clk);

        // Store with three wait states
        wait_cfg = 3;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h0000_0200;
        d_wdata  = 32'hDEAD_BEEF;
        exp_q.push_back(mk(1'b1, rdata_for(32'h200)));
        n = 0; ok_cnt = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                if (mem_we && mem_addr == 32'h200 && mem_wdata == 32'hDEAD_BEEF) ok_cnt++;
            end
            if (d_valid) begin
                nd++;
                d_req = 1'b0;
                d_we  = 1'b0;
            end
        end
        chk("wait_mem_req_cycles", 64'(n), 64'd4);
        chk("wait_mem_fields_stable", 64'(ok_cnt), 64'd4);
        chk("wait_valid_pulses", 64'(nd), 64'd1);

        // Starvation: both requesters held high
        wait_cfg = 0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0400;
        d_req    = 1'b1;
        d_addr   = 32'h0000_0800;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, rdata_for(32'h800 + 32'(4 * i))));
        exp_q.push_back(mk(1'b0, rdata_for(32'h400)));
        for (int i = 4; i < 8; i++) exp_q.push_back(mk(1'b1, rdata_for(32'h800 + 32'(4 * i))));
        exp_q.push_back(mk(1'b0, rdata_for(32'h404)));
        nd = 0; nf = 0;
        for (int i = 0; i < 200 && !(nd == 8 && nf == 2); i++) begin
            @(negedge clk);
            if (d_valid) begin
                nd++;
                if (nd == 8) d_req = 1'b0;
                else d_addr = d_addr + 32'd4;
            end
            if (if_valid) begin
                if (nd != 4 && nd != 8) chk("starve_fetch_position", 64'(nd), 64'd4);
                nf++;
                if (nf == 2) if_req = 1'b0;
                else if_addr = if_addr + 32'd4;
            end
        end
        chk("starve_data_count", 64'(nd), 64'd8);
        chk("starve_fetch_count", 64'(nf), 64'd2);
        repeat (2) @(negedge clk);

        // Reset while BUSY
        wait_cfg = 100;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0020;
        done     = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (mem_req) done = 1;
        end
        chk("rst_busy_reached", {63'd0, done}, 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {61'd0, mem_req, if_valid, d_valid}, 64'd0);
        @(negedge clk);
        chk("rst_held_outputs", {61'd0, mem_req, if_valid, d_valid}, 64'd0);
        wait_cfg = 0;
        exp_q.push_back(mk(1'b0, rdata_for(32'h20)));
        rst  = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_valid) begin
                if_req = 1'b0;
                done   = 1;
            end
        end
        chk("rst_refetch_done", {63'd0, done}, 64'd1);
        @(negedge clk);

        // Idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {59'd0, mem_req, if_valid, d_valid, stall_if, stall_mem}, 64'd0);
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage.
- Sequences each memory transaction with a req/ready handshake on the memory side.
- Returns read data and a one-cycle valid pulse to the winning requester.
- Drives per-stage stall signals so the pipeline holds IF or MEM until its access completes.

Parameters:
- ADDR_WIDTH, 32, width of byte address.
- DATA_WIDTH, 32, width of read/write data.
- STARVE_LIMIT, 4, number of consecutive data grants made while fetch waits before fetch is forced to win; range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request; held until if_valid
- if_addr  input  ADDR_WIDTH  fetch address; stable while if_req=1
- if_rdata  output  DATA_WIDTH  fetched instruction; meaningful only when if_valid=1
- if_valid  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request; held until d_valid
- d_we  input  1  1=store, 0=load; stable while d_req=1
- d_addr  input  ADDR_WIDTH  data address; stable while d_req=1
- d_wdata  input  DATA_WIDTH  store data; stable while d_req=1
- d_rdata  output  DATA_WIDTH  load data; meaningful only when d_valid=1
- d_valid  output  1  one-cycle data completion pulse
- stall_if  output  1  combinational: if_req & ~if_valid
- stall_mem  output  1  combinational: d_req & ~d_valid
- mem_req  output  1  memory request, registered
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_WIDTH  memory address, registered
- mem_wdata  output  DATA_WIDTH  memory write data, registered
- mem_ready  input  1  memory completes the access on the edge where mem_req=1 and mem_ready=1
- mem_rdata  input  DATA_WIDTH  read data, valid with mem_ready

Behaviour:
- Reset (asynchronous, rst=1): all registered outputs go to 0 immediately: mem_req, mem_we, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata. FSM goes to IDLE; starvation counter goes to 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise, at the edge, pick a winner, load mem_* from the winner's inputs, set mem_req=1, record grant_is_data, and go to BUSY.
- Arbitration in IDLE:
  - d_req alone → data wins.
  - if_req alone → fetch wins.
  - Both high → data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Starvation counter:
  - Increments on a data grant made while if_req=1.
  - Clears on any fetch grant, and on a data grant made while if_req=0.
  - Saturates at STARVE_LIMIT.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata hold constant.
  - On the edge where mem_ready=1: mem_rdata is captured into the granted requester's rdata register, that requester's valid is set to 1, mem_req and mem_we clear to 0, and the FSM goes to RESP.
  - Any number of wait cycles is allowed; there is no timeout.
- RESP:
  - Valid is high for exactly this one cycle; the requester advances on this edge.
  - At the edge: valid clears and the FSM goes to IDLE unconditionally. No grant is made in RESP, so a stale req is never re-served.
- rdata registers hold their value until the next completion for that requester.
- On a store completion, d_rdata is loaded from mem_rdata; its value is don't-care to the pipeline.
- Latency: a request high before edge N gives mem_req=1 after edge N. With mem_ready tied to 1, valid is high in cycle N+1→N+2. Minimum spacing between transactions is 3 cycles.
- if_valid and d_valid are never high in the same cycle. mem_req is never high in RESP or IDLE.
- Request dropped while its transaction is in BUSY: protocol violation; the transaction still completes and valid still pulses.
- Reset mid-BUSY: the transaction is abandoned, mem_req drops asynchronously, and no valid pulse is produced.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010, mem_ready=1, mem_rdata=0x0062_8293 → mem_addr=0x10, mem_we=0 for 1 cycle; if_valid pulses 1 cycle with if_rdata=0x0062_8293; stall_if high until that cycle.
- Simultaneous requests: if_req=1 (addr 0x14), d_req=1 load addr 0x100, zero-wait memory → data is served first (d_rdata from addr 0x100); the fetch grant starts in the IDLE following RESP; stall_if stays high 3 extra cycles.
- Wait states: d_req store, addr 0x200, wdata 0xDEAD_BEEF; mem_ready low for 3 cycles → mem_addr, mem_wdata and mem_we=1 stay constant for 4 cycles; d_valid pulses once after mem_ready.
- Starvation: STARVE_LIMIT=4, if_req held high, d_req re-asserted every IDLE → exactly 4 data grants, then a fetch grant, with the counter back at 0.
- Reset mid-BUSY: assert rst during BUSY with mem_ready=0 → mem_req=0 immediately, no valid pulse; after rst falls with if_req=1, a fresh fetch grant is made.
- Idle: no requests for 10 cycles → mem_req=0, both valids 0, both stalls 0 throughout.
